// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_pkg
// Description : Shared constants and FSM state types for the AXI4-Lite
//               register slave.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage : axi_lite_pkg
`default_nettype wire

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_regfile
// Description : NUM_REGS x DATA_WIDTH register storage with a synchronous
//               byte-strobed write port and a combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    // Each register updates only the byte lanes whose strobe is set.
    always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
        r_mem[g] <= '0;
      end else if (wr_en && (wr_idx == IDX_W'(g))) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (wr_strb[b]) begin
            r_mem[g][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read port is combinational so a read sampled on a write edge sees the old value.
  assign rd_data = r_mem[rd_idx];

endmodule : axi_lite_regfile
`default_nettype wire

// File: rtl/axi_lite_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_slave
// Description : AXI4-Lite slave exposing a bank of 32-bit read/write
//               registers. Write (AW/W/B) and read (AR/R) paths run
//               independently.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] c_addr_limit = ADDR_WIDTH'(4 * NUM_REGS);

  // Word-aligned and inside the register window.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    return (addr[1:0] == 2'b00) && (addr < c_addr_limit);
  endfunction

  wr_state_t r_wr_state, w_wr_state_nxt;
  rd_state_t r_rd_state, w_rd_state_nxt;

  logic                  r_awready, r_wready, r_arready;
  logic                  r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [STRB_W-1:0]     r_w_strb;
  logic [1:0]            r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_hs, w_w_hs, w_ar_hs;
  logic                  w_aw_avail, w_w_avail;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic                  w_wr_valid, w_rd_valid;
  logic                  w_commit;
  logic                  w_bvalid, w_rvalid;
  logic [DATA_WIDTH-1:0] w_reg_rdata;

  assign w_bvalid = (r_wr_state == W_RESP);
  assign w_rvalid = (r_rd_state == R_DATA);

  assign w_aw_hs = S_AXI_AWVALID && r_awready;
  assign w_w_hs  = S_AXI_WVALID  && r_wready;
  assign w_ar_hs = S_AXI_ARVALID && r_arready;

  // A channel is available either from its latch or from a handshake this
  // very edge, so AW+W arriving together commit on the handshake edge.
  assign w_aw_avail = r_aw_held || w_aw_hs;
  assign w_w_avail  = r_w_held  || w_w_hs;
  assign w_wr_addr  = r_aw_held ? r_aw_addr : S_AXI_AWADDR;
  assign w_wr_data  = r_w_held  ? r_w_data  : S_AXI_WDATA;
  assign w_wr_strb  = r_w_held  ? r_w_strb  : S_AXI_WSTRB;
  assign w_wr_valid = addr_ok(w_wr_addr);
  assign w_rd_valid = addr_ok(S_AXI_ARADDR);

  // Ready pulses: one cycle high, only when the channel can take a new beat.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_arready <= 1'b0;
    end else begin
      r_awready <= !r_awready && !r_aw_held && !w_bvalid && S_AXI_AWVALID;
      r_wready  <= !r_wready  && !r_w_held  && !w_bvalid && S_AXI_WVALID;
      r_arready <= !r_arready && !w_rvalid  && S_AXI_ARVALID;
    end
  end

  // Hold AW and W beats until both halves of the write are present.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= S_AXI_AWADDR;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= S_AXI_WDATA;
        r_w_strb <= S_AXI_WSTRB;
      end
    end
  end

  // Write FSM state register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_wr_state <= W_IDLE;
    else          r_wr_state <= w_wr_state_nxt;
  end

  // Write FSM: commit once both beats are in, then wait for BREADY.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_commit       = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (w_aw_avail && w_w_avail) begin
          w_commit       = 1'b1;
          w_wr_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_wr_state_nxt = W_IDLE;
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  // Capture the write response at commit; it stays put while BVALID is high.
  always_ff @(posedge ACLK) begin
    if (!ARESETN)      r_bresp <= RESP_OKAY;
    else if (w_commit) r_bresp <= w_wr_valid ? RESP_OKAY : RESP_SLVERR;
  end

  // Read FSM state register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_rd_state <= R_IDLE;
    else          r_rd_state <= w_rd_state_nxt;
  end

  // Read FSM: load on AR handshake, release on RREADY.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_ar_hs)      w_rd_state_nxt = R_DATA;
      R_DATA:  if (S_AXI_RREADY) w_rd_state_nxt = R_IDLE;
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // Read data/response capture; invalid addresses return zero with SLVERR.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_valid ? w_reg_rdata : '0;
      r_rresp <= w_rd_valid ? RESP_OKAY : RESP_SLVERR;
    end
  end

  axi_lite_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .wr_en   (w_commit && w_wr_valid),
    .wr_idx  (w_wr_addr[IDX_W+1:2]),
    .wr_data (w_wr_data),
    .wr_strb (w_wr_strb),
    .rd_idx  (S_AXI_ARADDR[IDX_W+1:2]),
    .rd_data (w_reg_rdata)
  );

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = w_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = w_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;

endmodule : axi_lite_slave
`default_nettype wire

// File: tb/tb_axi_lite_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_slave
// Description : Self-checking bench for axi_lite_slave: directed vector
//               table plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int checks   = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_slave dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (AWADDR),
    .S_AXI_AWVALID (AWVALID),
    .S_AXI_AWREADY (AWREADY),
    .S_AXI_WDATA   (WDATA),
    .S_AXI_WSTRB   (WSTRB),
    .S_AXI_WVALID  (WVALID),
    .S_AXI_WREADY  (WREADY),
    .S_AXI_BRESP   (BRESP),
    .S_AXI_BVALID  (BVALID),
    .S_AXI_BREADY  (BREADY),
    .S_AXI_ARADDR  (ARADDR),
    .S_AXI_ARVALID (ARVALID),
    .S_AXI_ARREADY (ARREADY),
    .S_AXI_RDATA   (RDATA),
    .S_AXI_RRESP   (RRESP),
    .S_AXI_RVALID  (RVALID),
    .S_AXI_RREADY  (RREADY)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [1:0] resp, input logic [31:0] exp);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.exp_resp = resp; v.exp_data = exp;
    return v;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    logic aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    resp = 2'bxx;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      tick();
      if (aw_hs) begin AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin WVALID  = 1'b0; w_done  = 1'b1; end
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    if (!(aw_done && w_done)) begin
      check("write_handshake_timeout", 0, 1);
      return;
    end
    for (int n = 0; n < 20 && !BVALID; n++) tick();
    if (!BVALID) begin
      check("bvalid_timeout", 0, 1);
      return;
    end
    resp = BRESP;
    tick();
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [1:0] resp, output logic [31:0] data);
    logic done = 1'b0, hs;
    resp = 2'bxx; data = 'x;
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      hs = ARVALID && ARREADY;
      tick();
      if (hs) begin ARVALID = 1'b0; done = 1'b1; end
    end
    ARVALID = 1'b0;
    if (!done) begin
      check("read_handshake_timeout", 0, 1);
      return;
    end
    for (int n = 0; n < 20 && !RVALID; n++) tick();
    if (!RVALID) begin
      check("rvalid_timeout", 0, 1);
      return;
    end
    resp = RRESP;
    data = RDATA;
    tick();
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;

    ARESETN = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b1;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b1;
    repeat (3) tick();
    ARESETN = 1'b1;
    tick();

    // Reset state of every output
    check("reset_outputs",
          {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA},
          64'h0);
    for (int a = 0; a < 16; a += 4) begin
      axi_read(32'(a), resp, data);
      check($sformatf("reset_read_0x%0h", a), {resp, data}, {2'b00, 32'h0});
    end

    // Concurrent AW+W+AR to 0xC: read returns old value
    AWADDR = 32'hC; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; ARADDR = 32'hC;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    check("coll_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check("coll_b", {BVALID, BRESP}, {1'b1, 2'b00});
    check("coll_r_old", {RVALID, RRESP, RDATA}, {1'b1, 2'b00, 32'h0});
    tick();
    check("coll_clear", {BVALID, RVALID}, 2'b00);
    axi_read(32'hC, resp, data);
    check("coll_readback", {resp, data}, {2'b00, 32'hDEADBEEF});

    // Directed vector table
    vecs.push_back(mk(1, 32'h4,  32'hFFFFFFFF, 4'hF,    2'b00, 32'h0));
    vecs.push_back(mk(1, 32'h4,  32'h12345678, 4'b0101, 2'b00, 32'h0));
    vecs.push_back(mk(0, 32'h4,  32'h0,        4'h0,    2'b00, 32'hFF34FF78));
    vecs.push_back(mk(1, 32'h0,  32'hA5A5A5A5, 4'hF,    2'b00, 32'h0));
    vecs.push_back(mk(1, 32'h0,  32'h00000011, 4'b0001, 2'b00, 32'h0));
    vecs.push_back(mk(0, 32'h0,  32'h0,        4'h0,    2'b00, 32'hA5A5A511));
    vecs.push_back(mk(1, 32'h8,  32'h0BADF00D, 4'b1100, 2'b00, 32'h0));
    vecs.push_back(mk(0, 32'h8,  32'h0,        4'h0,    2'b00, 32'h0BAD0000));
    vecs.push_back(mk(1, 32'h10, 32'h11111111, 4'hF,    2'b10, 32'h0));
    vecs.push_back(mk(1, 32'h9,  32'h22222222, 4'hF,    2'b10, 32'h0));
    vecs.push_back(mk(0, 32'h2,  32'h0,        4'h0,    2'b10, 32'h0));
    vecs.push_back(mk(0, 32'h10, 32'h0,        4'h0,    2'b10, 32'h0));
    vecs.push_back(mk(0, 32'h0,  32'h0,        4'h0,    2'b00, 32'hA5A5A511));
    vecs.push_back(mk(0, 32'h4,  32'h0,        4'h0,    2'b00, 32'hFF34FF78));
    vecs.push_back(mk(0, 32'h8,  32'h0,        4'h0,    2'b00, 32'h0BAD0000));
    vecs.push_back(mk(0, 32'hC,  32'h0,        4'h0,    2'b00, 32'hDEADBEEF));
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
      end else begin
        axi_read(vecs[i].addr, resp, data);
        check($sformatf("vec%0d_read", i), {resp, data}, {vecs[i].exp_resp, vecs[i].exp_data});
      end
    end

    // W raised three cycles before AW
    WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    check("wfirst_wready", {WREADY, AWREADY}, 2'b10);
    tick();
    WVALID = 1'b0;
    check("wfirst_no_b1", BVALID, 1'b0);
    tick();
    check("wfirst_no_b2", {BVALID, WREADY}, 2'b00);
    AWADDR = 32'h8; AWVALID = 1'b1;
    tick();
    check("wfirst_awready", {AWREADY, BVALID}, 2'b10);
    tick();
    AWVALID = 1'b0;
    check("wfirst_b", {BVALID, BRESP}, {1'b1, 2'b00});
    tick();
    check("wfirst_b_clear", BVALID, 1'b0);
    axi_read(32'h8, resp, data);
    check("wfirst_readback", {resp, data}, {2'b00, 32'hCAFEF00D});

    // Back-pressure on B and R for five cycles
    BREADY = 1'b0; RREADY = 1'b0;
    AWADDR = 32'h4; WDATA = 32'h01020304; WSTRB = 4'hF; ARADDR = 32'hC;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    tick();
    WVALID = 1'b0;
    AWADDR = 32'h0; ARADDR = 32'h0;
    for (int n = 0; n < 5; n++) begin
      check($sformatf("stall_hold%0d", n),
            {BVALID, BRESP, RVALID, RRESP, RDATA, AWREADY, ARREADY},
            {1'b1, 2'b00, 1'b1, 2'b00, 32'hDEADBEEF, 1'b0, 1'b0});
      tick();
    end
    AWVALID = 1'b0; ARVALID = 1'b0;
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    check("stall_release", {BVALID, RVALID}, 2'b00);
    axi_read(32'h4, resp, data);
    check("stall_readback", {resp, data}, {2'b00, 32'h01020304});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule : tb_axi_lite_slave
`default_nettype wire
